rom_stream_reader: RTL and testbench
====================================

# rom_stream_reader

Read-side controller for the single-port synchronous coefficient ROMs (twiddle factors, constant tables) in the lattice-crypto datapath. On a start request it drives the ROM's `enable`/`address` port over a contiguous, wrapping address range. It absorbs the ROM's one-cycle read latency and presents the words as a valid/ready stream with a last-word flag. Downstream NTT/multiplier stages consume this stream and may stall it at any time without losing data.

## Interface
- `MEM_WIDTH`, default 32: ROM word width in bits.
- `MEM_DEPTH`, default 1024: ROM depth in words. `AW = $clog2(MEM_DEPTH)`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a burst; sampled only in IDLE.
- `base_addr`  in  AW  first ROM address; sampled with `start`.
- `count`  in  AW+1  number of words, 0..MEM_DEPTH; sampled with `start`.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst end.
- `rom_enable`  out  1  ROM read enable.
- `rom_address`  out  AW  ROM address.
- `rom_dout`  in  MEM_WIDTH  ROM registered read data, valid the cycle after `rom_enable`.
- `out_data`  out  MEM_WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  marks the final word of a burst; qualified by `out_valid`.

## Operation
- States:
  - IDLE: waits for `start`.
  - FETCH: issues reads.
  - DRAIN: all reads issued, stream emptying.
- IDLE, `start`=1:
  - `count`>0: latch `base_addr` into the address counter and `count` into the remaining counter; go to FETCH.
  - `count`=0: pulse `done` the next cycle and stay IDLE. No reads are issued.
- `start` while not IDLE: ignored.
- Output buffer: 2-entry FIFO plus a 1-bit in-flight flag (a read issued last cycle).
- Read issue in FETCH: `rom_enable`=1 iff remaining>0 and (occupancy + inflight − pop) < 2, where pop = `out_valid & out_ready`.
- On each issue:
  - the address increments modulo MEM_DEPTH, so `MEM_DEPTH-1` wraps to 0;
  - remaining decrements.
- remaining reaching 0 moves the FSM to DRAIN.
- The cycle after an issue, `rom_dout` is pushed into the FIFO. Push and pop in the same cycle are both honoured.
- `out_data`/`out_valid` come from the FIFO head.
- `out_last`=1 when the head is the burst's final word.
- `rom_address` holds its last value when `rom_enable`=0.
- DRAIN → IDLE on the handshake of the last word. `done` pulses the cycle after that handshake, with `busy`=0 in that same cycle.
- `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_enable`=0, `rom_address`=0, `out_valid`=0, `out_last`=0, `out_data`=0. FIFO is empty, in-flight is 0, state is IDLE.
- Reset during a burst clears everything at that edge. A pending `rom_dout` is discarded and never appears on the stream.
- Let E0 be the edge that samples `start`:
  - `busy`=1 from E0.
  - First `rom_enable` is in the cycle following E0 (cycle 1).
  - Push happens at the end of cycle 2.
  - First `out_valid` is in cycle 3.
- Throughput is one word per cycle while `out_ready`=1.
- With `out_ready`=0, at most 2 words are buffered, then `rom_enable` stays 0.
- A burst of N words with `out_ready` held at 1: last handshake in cycle N+2, `done` in cycle N+3.
- A new `start` is accepted in the `done` cycle.

## Configuration
- `ROM_STREAM_READER_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in FETCH or DRAIN flushes the FIFO, discards the in-flight read and returns to IDLE at that edge.
  - Next cycle: `out_valid`=0, `busy`=0, and `done` is NOT pulsed.
  - `abort` in IDLE has no effect.
  - `abort` takes priority over a same-cycle handshake: the word is consumed downstream but the burst still ends.
- Not defined: the port is absent, and bursts always run to completion.

## Test plan
- Basic burst: base=5, count=4, `out_ready`=1.
  - Expect: addresses 5,6,7,8 on `rom_enable` in cycles 1–4; data in cycles 3–6; `out_last` in cycle 6; `done` in cycle 7.
- Wrap: base=MEM_DEPTH-2, count=4.
  - Expect: addresses MEM_DEPTH-2, MEM_DEPTH-1, 0, 1, and data in that order.
- Backpressure: count=8, `out_ready` toggling randomly with 3-cycle stalls.
  - Expect: all 8 words in order with no duplicates.
  - Expect: never more than 2 reads outstanding beyond accepted data.
  - Expect: `out_data` stable while stalled.
- Edge counts: count=0 → `done` the next cycle and no `rom_enable`. count=MEM_DEPTH → all words, with `out_last` only on the final one.
- Reset mid-burst: assert `reset_n`=0 in cycle 4 of a 10-word burst.
  - Expect: all outputs at reset values next cycle.
  - Expect: a fresh burst of 3 returns only its own 3 words.
- Abort (macro defined): `abort` in cycle 5 of a 10-word burst.
  - Expect: `out_valid`=0 and `busy`=0 next cycle, with no `done`.
  - Expect: a following burst streams correctly.

Source files
------------

// File: rtl/rom_stream_reader.sv
// Streams a contiguous, wrapping range of ROM words out as valid/ready data with a last flag.
// Optional `define ROM_STREAM_READER_ABORT_EN adds an abort input that cancels a burst without a done pulse.
module rom_stream_reader #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          count,
`ifdef ROM_STREAM_READER_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 rom_enable,
    output logic [AW-1:0]        rom_address,
    input  logic [MEM_WIDTH-1:0] rom_dout,
    output logic [MEM_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_reg;
    logic [AW-1:0]        addr_reg;
    logic [AW-1:0]        last_addr_reg;
    logic [AW:0]          remaining_reg;
    logic                 inflight_reg;
    logic                 inflight_last_reg;
    logic                 done_reg;
    logic                 wr_ptr_reg;
    logic                 rd_ptr_reg;
    logic [1:0]           occ_reg;
    logic [MEM_WIDTH-1:0] fifo_data_reg [2];
    logic [1:0]           fifo_last_reg;

    logic                 abort_hit;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 last_issue;
    logic                 last_pop;
    logic [2:0]           fill_after;

`ifdef ROM_STREAM_READER_ABORT_EN
    assign abort_hit = abort && (state_reg != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Words that will occupy the FIFO after this cycle if no new read is issued.
    assign fill_after = 3'(occ_reg) + 3'(inflight_reg) - 3'(pop);

    assign out_valid  = (occ_reg != 2'd0);
    assign out_data   = fifo_data_reg[rd_ptr_reg];
    assign out_last   = out_valid && fifo_last_reg[rd_ptr_reg];
    assign pop        = out_valid && out_ready;
    assign push       = inflight_reg && !abort_hit;
    assign last_pop   = pop && out_last;
    assign issue      = (state_reg == ST_FETCH) && (remaining_reg != '0)
                        && (fill_after < 3'd2) && !abort_hit;
    assign last_issue = issue && (remaining_reg == (AW+1)'(1));

    assign rom_enable  = issue;
    assign rom_address = issue ? addr_reg : last_addr_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            addr_reg          <= '0;
            last_addr_reg     <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            done_reg          <= 1'b0;
            inflight_reg      <= issue;
            inflight_last_reg <= last_issue;
            if (abort_hit) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            if (count == '0) begin
                                done_reg <= 1'b1;
                            end else begin
                                addr_reg      <= base_addr;
                                remaining_reg <= count;
                                state_reg     <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (issue) begin
                            addr_reg      <= (addr_reg == AW'(MEM_DEPTH - 1)) ? '0 : addr_reg + AW'(1);
                            last_addr_reg <= addr_reg;
                            remaining_reg <= remaining_reg - (AW+1)'(1);
                            if (last_issue) begin
                                state_reg <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (last_pop) begin
                            state_reg <= ST_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // FIFO bookkeeping; an abort empties the buffer and realigns the pointers.
    always_ff @(posedge clock) begin
        if (!reset_n || abort_hit) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            occ_reg <= occ_reg + 2'(push) - 2'(pop);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                fifo_data_reg[gi] <= '0;
                fifo_last_reg[gi] <= 1'b0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                fifo_data_reg[gi] <= rom_dout;
                fifo_last_reg[gi] <= inflight_last_reg;
            end
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomized bench for rom_stream_reader: a queue-based model predicts addresses, words and handshakes.
// Defining ROM_STREAM_READER_ABORT_EN also exercises the abort path.
module tb_rom_stream_reader;

    localparam int D  = 64;
    localparam int W  = 32;
    localparam int AW = $clog2(D);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          rom_enable;
    logic [AW-1:0] rom_address;
    logic [W-1:0]  rom_dout;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef ROM_STREAM_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    rom_stream_reader #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .base_addr(base_addr),
        .count(count),
`ifdef ROM_STREAM_READER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .done(done),
        .rom_enable(rom_enable),
        .rom_address(rom_address),
        .rom_dout(rom_dout),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clock = !clock;

    // ROM with one-cycle registered read
    logic [W-1:0] rom [D];
    always @(posedge clock) begin
        if (rom_enable) rom_dout <= rom[rom_address];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model state
    int           addr_q[$];
    logic [W-1:0] dq[$];
    bit           lq[$];
    bit           model_busy = 0;
    bit           exp_done = 0;
    bit           rst_chk = 0;
    bit           abort_chk = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           first_en_cyc = -1;
    int           first_valid_cyc = -1;
    int           last_hs_cyc = -1;
    int           done_cyc = -1;
    int           done_cnt = 0;
    int           issued = 0;
    int           popped = 0;
    int           lasts_seen = 0;
    int           addr_log[$];

    always @(negedge clock) begin
        cyc++;
        check("busy", busy, model_busy);
        check("done", done, exp_done);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst_chk)
            check("reset_outputs", {busy, done, rom_enable, out_valid, out_last, rom_address, out_data},
                  '0);
        if (abort_chk) check("abort_valid", out_valid, 0);
        rst_chk   = 0;
        abort_chk = 0;
        exp_done  = 0;
        if (!reset_n) begin
            addr_q.delete(); dq.delete(); lq.delete();
            model_busy = 0;
            rst_chk    = 1;
        end
`ifdef ROM_STREAM_READER_ABORT_EN
        else if (abort && model_busy) begin
            addr_q.delete(); dq.delete(); lq.delete();
            model_busy = 0;
            abort_chk  = 1;
        end
`endif
        else begin
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (dq.size() == 0) begin
                    check("unexpected_valid", out_valid, 0);
                end else begin
                    check("out_data", out_data, dq[0]);
                    check("out_last", out_last, lq[0]);
                    if (out_ready) begin
                        popped++;
                        if (lq[0]) begin
                            lasts_seen++;
                            last_hs_cyc = cyc;
                            model_busy  = 0;
                            exp_done    = 1;
                        end
                        void'(dq.pop_front());
                        void'(lq.pop_front());
                    end
                end
            end
            if (rom_enable) begin
                issued++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                addr_log.push_back(int'(rom_address));
                if (addr_q.size() == 0) begin
                    check("unexpected_enable", rom_enable, 0);
                end else begin
                    check("rom_address", rom_address, addr_q.pop_front());
                    check("outstanding", (issued - popped) <= 2, 1);
                end
            end
            if (start && !model_busy) begin
                start_cyc = cyc;
                first_en_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1;
                issued = 0; popped = 0; lasts_seen = 0;
                addr_log.delete();
                if (count == 0) begin
                    exp_done = 1;
                end else begin
                    model_busy = 1;
                    for (int i = 0; i < int'(count); i++) begin
                        addr_q.push_back((int'(base_addr) + i) % D);
                        dq.push_back(rom[(int'(base_addr) + i) % D]);
                        lq.push_back(i == int'(count) - 1);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // mode 0: always ready; mode 1: random ready with 3-cycle stalls
    task automatic run_burst(input int base, input int cnt, input int mode, input int max_cyc);
        int stall = 0;
        int d0 = done_cnt;
        start = 1; base_addr = AW'(base); count = (AW+1)'(cnt);
        tick;
        start = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (mode == 1) begin
                if (stall > 0) begin
                    out_ready = 0; stall--;
                end else if ($urandom_range(0, 3) == 0) begin
                    out_ready = 0; stall = 2;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                out_ready = 1;
            end
            tick;
            if (done_cnt != d0) break;
        end
        check("burst_done", done_cnt != d0, 1);
        out_ready = 1;
        $display("burst base=%0d count=%0d mode=%0d words=%0d start_cyc=%0d done_cyc=%0d",
                 base, cnt, mode, popped, start_cyc, done_cyc);
    endtask

    initial begin
        int wexp[4];
        for (int i = 0; i < D; i++) rom[i] = $urandom;
        reset_n = 0; start = 0; base_addr = '0; count = '0; out_ready = 1;
        repeat (3) tick;
        reset_n = 1;
        tick;

        // basic burst: pinned cycle offsets and addresses
        run_burst(5, 4, 0, 30);
        check("basic_first_en", first_en_cyc - start_cyc, 1);
        check("basic_first_valid", first_valid_cyc - start_cyc, 3);
        check("basic_last_hs", last_hs_cyc - start_cyc, 6);
        check("basic_done", done_cyc - start_cyc, 7);
        check("basic_n_addr", addr_log.size(), 4);
        if (addr_log.size() == 4)
            for (int i = 0; i < 4; i++) check("basic_addr", addr_log[i], 5 + i);

        // wrap at the top of the ROM
        run_burst(D - 2, 4, 1, 80);
        wexp = '{D - 2, D - 1, 0, 1};
        check("wrap_n_addr", addr_log.size(), 4);
        if (addr_log.size() == 4)
            for (int i = 0; i < 4; i++) check("wrap_addr", addr_log[i], wexp[i]);

        // backpressure
        run_burst(3, 8, 1, 200);
        check("bp_words", popped, 8);

        // zero-length burst
        run_burst(7, 0, 0, 10);
        check("zero_done", done_cyc - start_cyc, 1);
        check("zero_reads", issued, 0);

        // full-depth burst
        run_burst(9, D, 0, D + 20);
        check("full_words", popped, D);
        check("full_lasts", lasts_seen, 1);

        // reset in cycle 4 of a 10-word burst
        start = 1; base_addr = AW'(10); count = (AW+1)'(10);
        tick;
        start = 0;
        repeat (3) tick;
        reset_n = 0;
        tick;
        reset_n = 1;
        repeat (2) tick;
        run_burst(20, 3, 0, 40);
        check("post_reset_words", popped, 3);

`ifdef ROM_STREAM_READER_ABORT_EN
        // abort in cycle 5 of a 10-word burst
        begin
            int d0;
            d0 = done_cnt;
            start = 1; base_addr = AW'(30); count = (AW+1)'(10);
            tick;
            start = 0;
            repeat (4) tick;
            abort = 1;
            tick;
            abort = 0;
            repeat (3) tick;
            check("abort_no_done", done_cnt, d0);
            run_burst(40, 5, 1, 100);
            check("post_abort_words", popped, 5);
        end
`endif

        // randomized bursts
        repeat (12) begin
            run_burst(int'($urandom_range(0, D - 1)), int'($urandom_range(1, 20)),
                      int'($urandom_range(0, 1)), 400);
        end

        repeat (3) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
